bos_scan_ctrl: RTL
==================

# bos_scan_ctrl

Sequencer that drives the FPGA register-file write port (`master_data`/`valid_bus`) to run an automated BOS measurement scan. It powers the DUT rails up in order, then steps the Q[i] multiplexer through a channel range with optional load switching and a settle delay. At each channel it handshakes with an external measurement engine. When the scan ends it powers down in reverse order. It sits between the command decoder and the register block and shares that block's write port.

## Interface
Parameters:
- `SETTLE_CYC`, default 1000: clocks waited after mux and load writes before each measurement.
- `PWR_CYC`, default 50000: clocks waited after each rail enable.
- `TIMEOUT_CYC`, default 65535: maximum clocks from `meas_start` to `meas_done`.

Ports:
- `clk`, in, 1: system clock.
- `n_rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle pulse that begins a scan.
- `abort`, in, 1: single-cycle pulse that forces power-down.
- `ch_first`, in, 4: first mux channel, sampled at `start`.
- `ch_last`, in, 4: last mux channel, sampled at `start`.
- `load_sel`, in, 2: load pattern sampled at `start`. Bit 1 selects the 1.65 kOhm load; bit 0 selects the 240 Ohm load.
- `meas_start`, out, 1: single-cycle request to the measurement engine.
- `meas_done`, in, 1: single-cycle completion from the measurement engine.
- `master_data`, out, 8: register write data.
- `valid_bus`, out, 9: one-hot register write strobe. Bit k writes register k.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: single-cycle pulse when the scan sequence ends.
- `err_timeout`, out, 1: sticky flag; cleared by the next accepted `start`.
- `cur_ch`, out, 4: channel currently selected.

## Operation
Register map targeted:
- 0: mux address
- 1: loads (bit 1 = 3v7 load, bit 0 = pdr load)
- 6: functional
- 7: vcore
- 8: vdigital

Data 1 = on, 0 = off.

Write rules:
- At most one `valid_bus` bit is high per cycle.
- Each write strobe lasts exactly one cycle.
- Unused `master_data` bits are 0.

States and transitions:
- IDLE -> PWR_VC on `start`. `start` is ignored when `busy` is high.
- PWR_VC: write reg7 = 1. Then WAIT_VC for `PWR_CYC` clocks.
- PWR_VD: write reg8 = 1. Then WAIT_VD for `PWR_CYC` clocks.
- PWR_FN: write reg6 = 1. `cur_ch` <= `ch_first`.
- SET_ADDR: write reg0 = {4'b0, `cur_ch`}.
- SET_LOAD: write reg1 = {6'b0, `load_sel`}. This state is present only with the macro (see Configuration).
- SETTLE: wait `SETTLE_CYC` clocks.
- MEAS: pulse `meas_start`.
- WAIT_DONE:
  - On `meas_done`: if `cur_ch` == `ch_last`, go to PD_LOAD. Otherwise `cur_ch` <= `cur_ch` + 1 (mod 16) and go to SET_ADDR.
- Power-down sequence, one write per state:
  - PD_LOAD: reg1 = 0.
  - PD_FN: reg6 = 0.
  - PD_VD: reg8 = 0.
  - PD_VC: reg7 = 0.
  - Then DONE: pulse `done` and return to IDLE.

Boundary conditions:
- `ch_first` > `ch_last`: the scan wraps 15 -> 0. Example: first = 14, last = 1 scans 14, 15, 0, 1.
- `ch_first` == `ch_last`: exactly one channel is measured.
- Timeout: `meas_done` absent for `TIMEOUT_CYC` clocks in WAIT_DONE sets `err_timeout` and goes to PD_LOAD.
- Abort: `abort` in any non-IDLE state outside the PD_* states goes to PD_LOAD next cycle. Abort during PD_* or DONE is ignored.
- `abort` and `meas_done` in the same cycle: abort wins.
- `meas_done` outside WAIT_DONE is ignored.
- Reset mid-operation: all outputs return to their reset values immediately and the state goes to IDLE. The register block shares `n_rst`, so the rails are off as well.

## Timing
- Reset values:
  - `master_data` = 0, `valid_bus` = 0, `meas_start` = 0, `busy` = 0, `done` = 0, `err_timeout` = 0, `cur_ch` = 0.
  - State = IDLE; wait counter = 0.
- All outputs are registered.
- First write: `valid_bus[7]` is high in the cycle after `start` is sampled.
- Wait states last exactly N clocks. The counter loads N-1 on entry and exits when it reaches 0.
- `meas_start` is asserted the cycle after SETTLE expires.
- After `meas_done` is sampled, the next SET_ADDR write appears one cycle later.
- The wait counter is 17 bits wide. Parameters larger than 2^17-1 are illegal.

## Configuration
- `BOS_SCAN_LOAD_EN` defined:
  - SET_LOAD state is present; `load_sel` is written per channel.
  - PD_LOAD writes reg1 = 0.
- `BOS_SCAN_LOAD_EN` undefined:
  - SET_LOAD and PD_LOAD are bypassed. SET_ADDR goes directly to SETTLE; power-down starts at PD_FN.
  - `valid_bus[1]` is constant 0 and `load_sel` is unused.

## Structure
- Package `bos_pkg` holds:
  - register index constants: `REG_MUX` = 0, `REG_LOAD` = 1, `REG_FUNC` = 6, `REG_VCORE` = 7, `REG_VDIG` = 8;
  - the state enum;
  - `NUM_REGS` = 9.
- Sub-module `bos_wait_cnt`: a loadable down-counter with a `zero` flag. It is reused for the settle, power and timeout waits.

## Test plan
- Full scan (macro on): `start`, first = 0, last = 2, `load_sel` = 2'b10, `meas_done` 5 clocks after each `meas_start`.
  - Write order: reg7 = 1, reg8 = 1, reg6 = 1, then [reg0 = ch, reg1 = 2] for ch = 0, 1, 2.
  - Then reg1 = 0, reg6 = 0, reg8 = 0, reg7 = 0, and one `done` pulse.
  - Exactly 3 `meas_start` pulses.
- Wrap: first = 15, last = 0 -> mux writes 15 then 0. 
- Single channel: first = 5, last = 5 -> exactly one `meas_start` and one reg0 = 5 write.
- Timeout: `meas_done` withheld -> `err_timeout` = 1 after `TIMEOUT_CYC` clocks, power-down writes follow, then `done`. `err_timeout` clears on the next `start`.
- Abort during SETTLE: power-down begins the next cycle and `meas_start` is never pulsed. A `start` during `busy` is ignored.
- `n_rst` low during WAIT_DONE: all outputs are 0 immediately. After release, a new `start` runs the full sequence.

Source files
------------

// File: rtl/bos_pkg.sv
// rtl/bos_pkg.sv - register map, state encoding and strobe helper for the BOS scan sequencer
package bos_pkg;

    localparam int NUM_REGS  = 9;
    localparam int REG_MUX   = 0;
    localparam int REG_LOAD  = 1;
    localparam int REG_FUNC  = 6;
    localparam int REG_VCORE = 7;
    localparam int REG_VDIG  = 8;

    // Shared wait counter width; wait parameters must fit in it.
    localparam int CNT_W = 17;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PWR_VC    = 4'd1,
        S_WAIT_VC   = 4'd2,
        S_PWR_VD    = 4'd3,
        S_WAIT_VD   = 4'd4,
        S_PWR_FN    = 4'd5,
        S_SET_ADDR  = 4'd6,
        S_SET_LOAD  = 4'd7,
        S_SETTLE    = 4'd8,
        S_MEAS      = 4'd9,
        S_WAIT_DONE = 4'd10,
        S_PD_LOAD   = 4'd11,
        S_PD_FN     = 4'd12,
        S_PD_VD     = 4'd13,
        S_PD_VC     = 4'd14,
        S_DONE      = 4'd15
    } bos_state_e;

    // One-hot write strobe for register index idx.
    function automatic logic [NUM_REGS-1:0] wr_strobe(input int idx);
        logic [NUM_REGS-1:0] v;
        v = NUM_REGS'(1) << idx;
        return v;
    endfunction

endpackage

// File: rtl/bos_wait_cnt.sv
// rtl/bos_wait_cnt.sv - loadable down-counter with zero flag for settle, power and timeout waits
module bos_wait_cnt
    import bos_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_n_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bos_scan_ctrl.sv
// rtl/bos_scan_ctrl.sv - BOS scan sequencer top; optional per-channel load switching under BOS_SCAN_LOAD_EN
module bos_scan_ctrl
    import bos_pkg::*;
#(
    parameter int SETTLE_CYC  = 1000,
    parameter int PWR_CYC     = 50000,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] ch_first,
    input  logic [3:0] ch_last,
    input  logic [1:0] load_sel,
    output logic       meas_start,
    input  logic       meas_done,
    output logic [7:0] master_data,
    output logic [8:0] valid_bus,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic [3:0] cur_ch
);

    // Wait states last N clocks: counter is loaded with N-1 on entry.
    localparam logic [CNT_W-1:0] PWR_LD    = CNT_W'(PWR_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT_CYC - 1);

`ifdef BOS_SCAN_LOAD_EN
    localparam bos_state_e S_PD_ENTRY  = S_PD_LOAD;
    localparam bos_state_e S_AFTER_ADR = S_SET_LOAD;
`else
    localparam bos_state_e S_PD_ENTRY  = S_PD_FN;
    localparam bos_state_e S_AFTER_ADR = S_SETTLE;
`endif

    bos_state_e       r_state;
    bos_state_e       w_state_nxt;
    logic [3:0]       r_cur_ch;
    logic [3:0]       r_ch_first;
    logic [3:0]       r_ch_last;
    logic [3:0]       w_ch_nxt;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_timeout;
    logic             w_accept;
    logic             w_abort_ok;
    logic [8:0]       w_vb_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_meas_nxt;
    logic             w_done_nxt;
    logic [8:0]       r_valid_bus;
    logic [7:0]       r_master_data;
    logic             r_meas_start;
    logic             r_busy;
    logic             r_done;
    logic             r_err_timeout;

`ifdef BOS_SCAN_LOAD_EN
    logic [1:0]       r_load_sel;
`else
    logic             w_unused_load;
    assign w_unused_load = ^load_sel;
`endif

    bos_wait_cnt u_wait_cnt (
        .i_clk      (clk),
        .i_n_rst    (n_rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, channel stepping and wait-counter control; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_cur_ch;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        w_cnt_dec   = 1'b0;
        w_timeout   = 1'b0;
        w_accept    = 1'b0;
        w_abort_ok  = abort && !(r_state inside {S_IDLE, S_PD_LOAD, S_PD_FN,
                                                 S_PD_VD, S_PD_VC, S_DONE});
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_PWR_VC;
                    w_accept    = 1'b1;
                end
            end
            S_PWR_VC: begin
                w_state_nxt = S_WAIT_VC;
                w_cnt_load  = 1'b1;
                w_cnt_val   = PWR_LD;
            end
            S_WAIT_VC: begin
                if (w_cnt_zero) w_state_nxt = S_PWR_VD;
                else            w_cnt_dec   = 1'b1;
            end
            S_PWR_VD: begin
                w_state_nxt = S_WAIT_VD;
                w_cnt_load  = 1'b1;
                w_cnt_val   = PWR_LD;
            end
            S_WAIT_VD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_PWR_FN;
                    w_ch_nxt    = r_ch_first;
                end else begin
                    w_cnt_dec   = 1'b1;
                end
            end
            S_PWR_FN: begin
                w_state_nxt = S_SET_ADDR;
            end
            S_SET_ADDR: begin
                w_state_nxt = S_AFTER_ADR;
                w_cnt_load  = (S_AFTER_ADR == S_SETTLE);
                w_cnt_val   = SETTLE_LD;
            end
            S_SET_LOAD: begin
                w_state_nxt = S_SETTLE;
                w_cnt_load  = 1'b1;
                w_cnt_val   = SETTLE_LD;
            end
            S_SETTLE: begin
                if (w_cnt_zero) w_state_nxt = S_MEAS;
                else            w_cnt_dec   = 1'b1;
            end
            S_MEAS: begin
                w_state_nxt = S_WAIT_DONE;
                w_cnt_load  = 1'b1;
                w_cnt_val   = TMO_LD;
            end
            S_WAIT_DONE: begin
                if (meas_done) begin
                    if (r_cur_ch == r_ch_last) begin
                        w_state_nxt = S_PD_ENTRY;
                    end else begin
                        w_state_nxt = S_SET_ADDR;
                        w_ch_nxt    = r_cur_ch + 4'd1;
                    end
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_PD_ENTRY;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_dec   = 1'b1;
                end
            end
            S_PD_LOAD: w_state_nxt = S_PD_FN;
            S_PD_FN:   w_state_nxt = S_PD_VD;
            S_PD_VD:   w_state_nxt = S_PD_VC;
            S_PD_VC:   w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_abort_ok) begin
            w_state_nxt = S_PD_ENTRY;
            w_ch_nxt    = r_cur_ch;
            w_cnt_load  = 1'b0;
            w_cnt_dec   = 1'b0;
            w_timeout   = 1'b0;
        end
    end

    // Outputs are decoded from the next state so each registered strobe lines up with its state.
    always_comb begin
        w_vb_nxt   = '0;
        w_data_nxt = '0;
        w_meas_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_PWR_VC:   begin w_vb_nxt = wr_strobe(REG_VCORE); w_data_nxt = 8'd1; end
            S_PWR_VD:   begin w_vb_nxt = wr_strobe(REG_VDIG);  w_data_nxt = 8'd1; end
            S_PWR_FN:   begin w_vb_nxt = wr_strobe(REG_FUNC);  w_data_nxt = 8'd1; end
            S_SET_ADDR: begin w_vb_nxt = wr_strobe(REG_MUX);   w_data_nxt = {4'b0, w_ch_nxt}; end
`ifdef BOS_SCAN_LOAD_EN
            S_SET_LOAD: begin w_vb_nxt = wr_strobe(REG_LOAD);  w_data_nxt = {6'b0, r_load_sel}; end
            S_PD_LOAD:  w_vb_nxt = wr_strobe(REG_LOAD);
`endif
            S_MEAS:     w_meas_nxt = 1'b1;
            S_PD_FN:    w_vb_nxt = wr_strobe(REG_FUNC);
            S_PD_VD:    w_vb_nxt = wr_strobe(REG_VDIG);
            S_PD_VC:    w_vb_nxt = wr_strobe(REG_VCORE);
            S_DONE:     w_done_nxt = 1'b1;
            default:    w_vb_nxt = '0;
        endcase
    end

    // Scan configuration captured at start, and the current channel.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cur_ch   <= '0;
            r_ch_first <= '0;
            r_ch_last  <= '0;
`ifdef BOS_SCAN_LOAD_EN
            r_load_sel <= '0;
`endif
        end else begin
            r_cur_ch <= w_ch_nxt;
            if (w_accept) begin
                r_ch_first <= ch_first;
                r_ch_last  <= ch_last;
`ifdef BOS_SCAN_LOAD_EN
                r_load_sel <= load_sel;
`endif
            end
        end
    end

    // Registered outputs; timeout flag is sticky until the next accepted start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid_bus   <= '0;
            r_master_data <= '0;
            r_meas_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_valid_bus   <= w_vb_nxt;
            r_master_data <= w_data_nxt;
            r_meas_start  <= w_meas_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_done        <= w_done_nxt;
            if (w_accept)       r_err_timeout <= 1'b0;
            else if (w_timeout) r_err_timeout <= 1'b1;
        end
    end

    assign valid_bus   = r_valid_bus;
    assign master_data = r_master_data;
    assign meas_start  = r_meas_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_timeout = r_err_timeout;
    assign cur_ch      = r_cur_ch;

endmodule
